// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - two-road intersection light sequencer with emergency preemption
// Optional pedestrian walk phase enabled by defining PED_PHASE_EN.
module traffic_sequencer #(
  parameter int MIN_GREEN     = 4,
  parameter int MAX_GREEN     = 16,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 6,
  parameter int TW            = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       emg,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AG   = 3'd0,
    AY   = 3'd1,
    ARAB = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    ARBA = 3'd5,
    PED  = 3'd6,
    EMG  = 3'd7
  } state_t;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  localparam logic [TW-1:0] MIN_T    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_T    = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_T = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] ALLRED_T = TW'(ALLRED_CYCLES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          ped_pend;
  logic          a_green_done;
  logic          b_green_done;

`ifdef PED_PHASE_EN
  localparam logic [TW-1:0] WALK_T = TW'(WALK_CYCLES - 1);

  logic ped_pend_q, ped_pend_d;
  logic from_arba_q, from_arba_d;
  logic enter_ped;

  assign ped_pend  = ped_pend_q;
  assign enter_ped = (state_d == PED) && (state_q != PED);

  // A request arriving on the PED entry edge survives the clear.
  always_comb begin
    ped_pend_d  = ped_req | (ped_pend_q & ~enter_ped);
    from_arba_d = enter_ped ? (state_q == ARBA) : from_arba_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_q  <= 1'b0;
      from_arba_q <= 1'b0;
    end else begin
      ped_pend_q  <= ped_pend_d;
      from_arba_q <= from_arba_d;
    end
  end
`else
  logic unused_ped;

  assign ped_pend   = 1'b0;
  assign unused_ped = ped_req ^ (WALK_CYCLES == 0);
`endif

  assign a_green_done = ((t_q >= MIN_T) && (!Ta || ped_pend)) || (t_q == MAX_T);
  assign b_green_done = ((t_q >= MIN_T) && (!Tb || ped_pend)) || (t_q == MAX_T);

  always_comb begin
    state_d = state_q;
    case (state_q)
      AG: if (emg || a_green_done) state_d = AY;
      AY: if (t_q == YELLOW_T) state_d = ARAB;
      ARAB: begin
        if (t_q == ALLRED_T) begin
          if (emg)           state_d = EMG;
          else if (ped_pend) state_d = PED;
          else               state_d = BG;
        end
      end
      BG: if (emg || b_green_done) state_d = BY;
      BY: if (t_q == YELLOW_T) state_d = ARBA;
      ARBA: begin
        if (t_q == ALLRED_T) begin
          if (emg)           state_d = EMG;
          else if (ped_pend) state_d = PED;
          else               state_d = AG;
        end
      end
`ifdef PED_PHASE_EN
      PED: begin
        if (emg)                state_d = EMG;
        else if (t_q == WALK_T) state_d = from_arba_q ? AG : BG;
      end
`endif
      EMG: if (!emg) state_d = AG;
      default: state_d = AG;
    endcase
  end

  // Timer restarts on every state change and saturates instead of wrapping.
  always_comb begin
    t_d = t_q;
    if (state_d != state_q) t_d = '0;
    else if (t_q != '1)     t_d = t_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AG;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    La    = L_RED;
    Lb    = L_RED;
    walk  = 1'b0;
    phase = state_q;
    case (state_q)
      AG: La = L_GREEN;
      AY: La = L_YELLOW;
      BG: Lb = L_GREEN;
      BY: Lb = L_YELLOW;
`ifdef PED_PHASE_EN
      PED: walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
// tb/tb_traffic_sequencer.sv - directed self-checking bench for traffic_sequencer
// Pedestrian scenarios are selected by PED_PHASE_EN, matching the DUT build.
module tb_traffic_sequencer;

  logic       clk;
  logic       rst_n;
  logic       Ta;
  logic       Tb;
  logic       emg;
  logic       ped_req;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int passes = 0;

  traffic_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Ta      (Ta),
    .Tb      (Tb),
    .emg     (emg),
    .ped_req (ped_req),
    .La      (La),
    .Lb      (Lb),
    .walk    (walk),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_la(input int code);
    if (code == 0) return 2'b00;
    if (code == 1) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [1:0] exp_lb(input int code);
    if (code == 3) return 2'b00;
    if (code == 4) return 2'b01;
    return 2'b10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    Ta      = 1'b0;
    Tb      = 1'b0;
    emg     = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Ta = 1'b0; Tb = 1'b0; emg = 1'b0; ped_req = 1'b0;
    #2;
    checks++;
    if (La !== 2'b00 || Lb !== 2'b10 || walk !== 1'b0 || phase !== 3'd0) begin
      $display("FAIL reset_held: La=%b Lb=%b walk=%b phase=%0d, want La=00 Lb=10 walk=0 phase=0", La, Lb, walk, phase);
    end else passes++;
    do_reset();
    checks++;
    if (La !== 2'b00 || Lb !== 2'b10 || walk !== 1'b0 || phase !== 3'd0) begin
      $display("FAIL reset_release: La=%b Lb=%b walk=%b phase=%0d, want La=00 Lb=10 walk=0 phase=0", La, Lb, walk, phase);
    end else passes++;
  endtask

  task automatic test_normal();
    int c1[4] = '{0, 1, 2, 3};
    int n1[4] = '{4, 3, 1, 1};
    int c2[4] = '{3, 4, 5, 0};
    int n2[4] = '{3, 3, 1, 1};
    do_reset();
    Tb = 1'b1;
    foreach (c1[k]) for (int i = 0; i < n1[k]; i++) begin
      checks++;
      if (phase !== 3'(c1[k]) || La !== exp_la(c1[k]) || Lb !== exp_lb(c1[k]) || walk !== 1'b0) begin
        $display("FAIL normal_a seg%0d cyc%0d: phase=%0d La=%b Lb=%b walk=%b, want phase=%0d La=%b Lb=%b walk=0",
                 k, i, phase, La, Lb, walk, c1[k], exp_la(c1[k]), exp_lb(c1[k]));
      end else passes++;
      tick();
    end
    Tb = 1'b0;
    foreach (c2[k]) for (int i = 0; i < n2[k]; i++) begin
      checks++;
      if (phase !== 3'(c2[k]) || La !== exp_la(c2[k]) || Lb !== exp_lb(c2[k]) || walk !== 1'b0) begin
        $display("FAIL normal_b seg%0d cyc%0d: phase=%0d La=%b Lb=%b walk=%b, want phase=%0d La=%b Lb=%b walk=0",
                 k, i, phase, La, Lb, walk, c2[k], exp_la(c2[k]), exp_lb(c2[k]));
      end else passes++;
      tick();
    end
  endtask

  task automatic test_max_green();
    int c[2] = '{0, 1};
    int n[2] = '{16, 1};
    do_reset();
    Ta = 1'b1;
    Tb = 1'b1;
    foreach (c[k]) for (int i = 0; i < n[k]; i++) begin
      checks++;
      if (phase !== 3'(c[k]) || La !== exp_la(c[k]) || Lb !== exp_lb(c[k])) begin
        $display("FAIL max_green seg%0d cyc%0d: phase=%0d La=%b Lb=%b, want phase=%0d La=%b Lb=%b",
                 k, i, phase, La, Lb, c[k], exp_la(c[k]), exp_lb(c[k]));
      end else passes++;
      tick();
    end
  endtask

  task automatic test_emg();
    int c1[5] = '{0, 0, 1, 2, 7};
    int n1[5] = '{1, 1, 3, 1, 5};
    int c2[2] = '{7, 0};
    do_reset();
    Ta = 1'b1;
    Tb = 1'b1;
    foreach (c1[k]) begin
      if (k == 1) emg = 1'b1;
      for (int i = 0; i < n1[k]; i++) begin
        checks++;
        if (phase !== 3'(c1[k]) || La !== exp_la(c1[k]) || Lb !== exp_lb(c1[k]) || walk !== 1'b0) begin
          $display("FAIL emg_hold seg%0d cyc%0d: phase=%0d La=%b Lb=%b walk=%b, want phase=%0d La=%b Lb=%b walk=0",
                   k, i, phase, La, Lb, walk, c1[k], exp_la(c1[k]), exp_lb(c1[k]));
        end else passes++;
        tick();
      end
    end
    emg = 1'b0;
    foreach (c2[k]) begin
      checks++;
      if (phase !== 3'(c2[k]) || La !== exp_la(c2[k]) || Lb !== exp_lb(c2[k])) begin
        $display("FAIL emg_release step%0d: phase=%0d La=%b Lb=%b, want phase=%0d La=%b Lb=%b",
                 k, phase, La, Lb, c2[k], exp_la(c2[k]), exp_lb(c2[k]));
      end else passes++;
      tick();
    end
  endtask

`ifdef PED_PHASE_EN
  task automatic test_ped();
    int c1[4] = '{0, 1, 2, 6};
    int n1[4] = '{2, 3, 1, 6};
    int c2[4] = '{3, 4, 5, 0};
    int n2[4] = '{4, 3, 1, 2};
    do_reset();
    Ta = 1'b1;
    Tb = 1'b1;
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    foreach (c1[k]) for (int i = 0; i < n1[k]; i++) begin
      checks++;
      if (phase !== 3'(c1[k]) || La !== exp_la(c1[k]) || Lb !== exp_lb(c1[k]) || walk !== (c1[k] == 6)) begin
        $display("FAIL ped_walk seg%0d cyc%0d: phase=%0d La=%b Lb=%b walk=%b, want phase=%0d La=%b Lb=%b walk=%0d",
                 k, i, phase, La, Lb, walk, c1[k], exp_la(c1[k]), exp_lb(c1[k]), c1[k] == 6);
      end else passes++;
      tick();
    end
    Tb = 1'b0;
    Ta = 1'b0;
    foreach (c2[k]) for (int i = 0; i < n2[k]; i++) begin
      checks++;
      if (phase !== 3'(c2[k]) || walk !== 1'b0) begin
        $display("FAIL ped_cleared seg%0d cyc%0d: phase=%0d walk=%b, want phase=%0d walk=0",
                 k, i, phase, walk, c2[k]);
      end else passes++;
      tick();
    end
  endtask

  task automatic test_emg_in_ped();
    int c1[4] = '{0, 1, 2, 6};
    int n1[4] = '{2, 3, 1, 2};
    int c2[5] = '{6, 7, 7, 7, 0};
    do_reset();
    Ta = 1'b1;
    Tb = 1'b1;
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    foreach (c1[k]) for (int i = 0; i < n1[k]; i++) begin
      checks++;
      if (phase !== 3'(c1[k])) begin
        $display("FAIL emg_ped_lead seg%0d cyc%0d: phase=%0d, want %0d", k, i, phase, c1[k]);
      end else passes++;
      tick();
    end
    emg = 1'b1;
    foreach (c2[k]) begin
      if (k == 3) emg = 1'b0;
      checks++;
      if (phase !== 3'(c2[k]) || walk !== (c2[k] == 6) || La !== exp_la(c2[k]) || Lb !== exp_lb(c2[k])) begin
        $display("FAIL emg_ped step%0d: phase=%0d walk=%b La=%b Lb=%b, want phase=%0d walk=%0d La=%b Lb=%b",
                 k, phase, walk, La, Lb, c2[k], c2[k] == 6, exp_la(c2[k]), exp_lb(c2[k]));
      end else passes++;
      tick();
    end
  endtask
`else
  task automatic test_no_ped();
    int c[5] = '{0, 1, 2, 3, 3};
    int n[5] = '{4, 3, 1, 1, 1};
    do_reset();
    Tb = 1'b1;
    foreach (c[k]) for (int i = 0; i < n[k]; i++) begin
      ped_req = (i == 0);
      checks++;
      if (phase !== 3'(c[k]) || walk !== 1'b0) begin
        $display("FAIL no_ped_seq seg%0d cyc%0d: phase=%0d walk=%b, want phase=%0d walk=0", k, i, phase, walk, c[k]);
      end else passes++;
      tick();
    end
    Ta = 1'b0;
    Tb = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ped_req = (i % 5 == 1);
      checks++;
      if (walk !== 1'b0 || phase === 3'd6) begin
        $display("FAIL no_ped_walk cyc%0d: phase=%0d walk=%b, want phase!=6 walk=0", i, phase, walk);
      end else passes++;
      tick();
    end
    ped_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int c1[5] = '{0, 1, 2, 3, 4};
    int n1[5] = '{4, 3, 1, 4, 1};
    int c2[2] = '{0, 1};
    int n2[2] = '{4, 1};
    do_reset();
    foreach (c1[k]) for (int i = 0; i < n1[k]; i++) begin
      checks++;
      if (phase !== 3'(c1[k])) begin
        $display("FAIL reset_mid_lead seg%0d cyc%0d: phase=%0d, want %0d", k, i, phase, c1[k]);
      end else passes++;
      tick();
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (La !== 2'b00 || Lb !== 2'b10 || phase !== 3'd0 || walk !== 1'b0) begin
      $display("FAIL reset_async: La=%b Lb=%b phase=%0d walk=%b, want La=00 Lb=10 phase=0 walk=0", La, Lb, phase, walk);
    end else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (c2[k]) for (int i = 0; i < n2[k]; i++) begin
      checks++;
      if (phase !== 3'(c2[k])) begin
        $display("FAIL reset_mid_restart seg%0d cyc%0d: phase=%0d, want %0d", k, i, phase, c2[k]);
      end else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_max_green();
    test_emg();
`ifdef PED_PHASE_EN
    test_ped();
    test_emg_in_ped();
`else
    test_no_ped();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Timed, sensor-driven controller for a two-road intersection (road A, road B). Sequences both light pairs through green, yellow and all-red phases, enforcing minimum and maximum green times. Supports emergency preemption and an optional pedestrian walk phase. Sits above the light-decode logic and drives the La/Lb light codes directly.

## Interface
- MIN_GREEN, 4, minimum green cycles per road (≥1, ≤ MAX_GREEN)
- MAX_GREEN, 16, maximum green cycles per road (< 2^TW)
- YELLOW_CYCLES, 3, yellow duration (≥1)
- ALLRED_CYCLES, 1, all-red clearance duration (≥1)
- WALK_CYCLES, 6, pedestrian walk duration (≥1); used only with PED_PHASE_EN
- TW, 8, phase timer width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Ta  in  1  road A traffic present
- Tb  in  1  road B traffic present
- emg  in  1  emergency preemption request, level
- ped_req  in  1  pedestrian request; a 1-cycle pulse is sufficient
- La  out  2  road A light: 00 green, 01 yellow, 10 red
- Lb  out  2  road B light, same encoding
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state code, for debug

## Operation
- States and codes: AG=0, AY=1, ARAB=2, BG=3, BY=4, ARBA=5, PED=6, EMG=7.
- Timer t: TW bits. Clears to 0 on every state change, otherwise increments, saturating at all-ones.
- ped_pend: set by ped_req. Cleared on the edge that enters PED. If set and cleared in the same cycle, the set wins.
- AG: go to AY if emg. Otherwise go to AY when (t ≥ MIN_GREEN-1 and (~Ta or ped_pend)) or t == MAX_GREEN-1.
- BG: same rule, using Tb; go to BY.
- AY → ARAB and BY → ARBA when t == YELLOW_CYCLES-1. Yellow always runs its full duration, including under emg.
- ARAB: at t == ALLRED_CYCLES-1, next state by priority: emg → EMG; ped_pend → PED; otherwise BG.
- ARBA: same priority; the default next state is AG.
- PED: emg → EMG immediately. Otherwise, at t == WALK_CYCLES-1, go to BG if entered from ARAB, or AG if entered from ARBA. A 1-bit flag records the entry side.
- EMG: hold while emg = 1. Go to AG on the first cycle emg = 0.
- Output decode (Moore, from the state register only):
  - AG: La=00, Lb=10
  - AY: La=01, Lb=10
  - BG: La=10, Lb=00
  - BY: La=10, Lb=01
  - ARAB, ARBA, PED, EMG: La=Lb=10
  - walk=1 only in PED.
- Invariant: La and Lb are never both non-red.

## Timing
- Reset: state AG, t=0, ped_pend=0, entry flag=0, La=00, Lb=10, walk=0, phase=0.
- Reset is asynchronous. Asserting it mid-phase forces the reset values immediately, regardless of the current state.
- Light change latency: outputs change on the same edge that updates the state register; there is no additional pipeline.
- A phase of N cycles occupies exactly N rising edges, counting from its entry edge.
- ped_req and emg are sampled each edge. Inputs are assumed synchronous to clk; synchronizers live outside this block.

## Configuration
- PED_PHASE_EN defined: ped_pend logic, the PED state and the walk output are active as described above.
- PED_PHASE_EN undefined:
  - ped_req is ignored; ped_pend is constant 0.
  - PED is unreachable; an illegal state code recovers to AG.
  - walk is tied to 0.
  - ARAB/ARBA exit only to EMG or to the opposite green.

## Test plan
- Defaults, Ta=0, Tb=1, no emg/ped.
  - Required: AG for 4 cycles, AY 3, ARAB 1, then BG with Lb=00.
  - Then Tb=0: BG lasts 4 cycles, followed by BY and ARBA.
- Ta=1 held, Tb=1 held: AG lasts exactly 16 cycles (MAX_GREEN), then AY.
- ped_req pulse at cycle 1 of AG, Ta=1 (PED_PHASE_EN):
  - Required sequence: AG 4, AY 3, ARAB 1, PED 6 with walk=1 and La=Lb=10, then BG.
  - ped_pend=0 after PED entry.
- emg asserted at AG t=1:
  - Required: AY 3, ARAB 1, then EMG with La=Lb=10 for as long as emg is held.
  - Deassert emg: AG on the next edge.
- emg asserted during PED t=2: EMG on the next edge, walk=0. Without PED_PHASE_EN, ped_req pulses never produce walk=1.
- rst_n pulled low during BY: immediate La=00, Lb=10, phase=0. After release, AG runs with t starting at 0.
